// File: rtl/signed8x8_pp_accumulator.sv
// signed8x8_pp_accumulator
// Sequential shift-add consumer of the four sign-extended radix-4 Booth
// partial-product rows of a signed 8x8 multiplier. The rows and the final
// negate bit are summed modulo 2^16 into a two's-complement product.
// Valid/ready handshakes on both sides; one operand set in flight at a time.
//
// Build option: define PPACC_DUAL_ROW_EN to fold two rows into each add step.
// This shortens latency to 1 cycle after accept and the initiation interval
// to 3 cycles. The default build adds one row per cycle, with a latency of
// 3 cycles and an initiation interval of 5 cycles.

module signed8x8_pp_accumulator (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] pp00,
   input  logic [12:0] pp01,
   input  logic [12:0] pp02,
   input  logic [11:0] pp03,
   input  logic        neg3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
`ifndef PPACC_DUAL_ROW_EN
   logic [12:0] pp01_q, pp01_d;
`endif
   logic [12:0] pp02_q, pp02_d;
   logic [11:0] pp03_q, pp03_d;

   // Rows aligned to their bit weights inside the 16-bit accumulator.
   // Bits shifted past bit 15 are dropped on purpose: the sign-extension
   // constants carried in the rows only cancel under modulo-2^16 wrap.
   logic [15:0] row0_w, row1_in_w, neg3_w, row2_w, row3_w;
`ifndef PPACC_DUAL_ROW_EN
   logic [15:0] row1_q_w;
`endif

   // Zero-extend and shift each row to its weight in the accumulator.
   always_comb begin
      row0_w    = {4'b0000, pp00};
      row1_in_w = {3'b000, pp01};
      neg3_w    = {9'b0_0000_0000, neg3, 6'b00_0000};
      row2_w    = {1'b0, pp02_q, 2'b00};
      row3_w    = {pp03_q, 4'b0000};
`ifndef PPACC_DUAL_ROW_EN
      row1_q_w  = {3'b000, pp01_q};
`endif
   end

   // Next-state, accumulator and operand-capture logic; holds everything by default.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifndef PPACC_DUAL_ROW_EN
      pp01_d  = pp01_q;
`endif
      pp02_d  = pp02_q;
      pp03_d  = pp03_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef PPACC_DUAL_ROW_EN
               // Rows 0 and 1 go in together; rows 2 and 3 follow in a single step.
               acc_d   = row0_w + row1_in_w + neg3_w;
               cnt_d   = 2'd2;
`else
               // Row 0 and the row-3 negate bit seed the accumulator.
               pp01_d  = pp01;
               acc_d   = row0_w + neg3_w;
               cnt_d   = 2'd1;
`endif
               pp02_d  = pp02;
               pp03_d  = pp03;
               state_d = ACC;
            end
         end

         ACC: begin
`ifdef PPACC_DUAL_ROW_EN
            if (cnt_q == 2'd2) begin
               acc_d   = acc_q + row2_w + row3_w;
               state_d = DONE;
            end else begin
               // Counter values other than 2 cannot occur in this build.
               state_d = IDLE;
            end
`else
            case (cnt_q)
               2'd1: begin
                  acc_d = acc_q + row1_q_w;
                  cnt_d = 2'd2;
               end
               2'd2: begin
                  acc_d = acc_q + row2_w;
                  cnt_d = 2'd3;
               end
               2'd3: begin
                  acc_d   = acc_q + row3_w;
                  state_d = DONE;
               end
               default: begin
                  // A counter of 0 in ACC cannot occur; return to a safe state.
                  state_d = IDLE;
               end
            endcase
`endif
         end

         DONE: begin
            // acc keeps its value after the transfer; only out_valid drops.
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, accumulator and operand registers; reset drops any result in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= 16'h0000;
         cnt_q   <= 2'd0;
`ifndef PPACC_DUAL_ROW_EN
         pp01_q  <= 13'd0;
`endif
         pp02_q  <= 13'd0;
         pp03_q  <= 12'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifndef PPACC_DUAL_ROW_EN
         pp01_q  <= pp01_d;
`endif
         pp02_q  <= pp02_d;
         pp03_q  <= pp03_d;
      end
   end

   // Handshake outputs decode the registered state only, with no path from the inputs.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      product   = acc_q;
   end

endmodule

// File: doc/signed8x8_pp_accumulator.md
# signed8x8_pp_accumulator

Sequential consumer of the four sign-extended radix-4 Booth partial products of the signed 8×8 multiplier. It sums them, plus the final-row negate bit, into a 16-bit two's-complement product. Multi-cycle shift-add datapath with valid/ready handshakes on both sides. It replaces a combinational compressor tree where area matters more than throughput.

## Interface
Parameters:
- none. Widths are fixed by the 8×8 signed Booth format.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- pp00  in  12  row 0, LSB weight 2^0.
- pp01  in  13  row 1, LSB weight 2^0 (carries sign[0] in bit 0).
- pp02  in  13  row 2, LSB weight 2^2.
- pp03  in  12  row 3, LSB weight 2^4.
- neg3  in  1  negate bit of Booth row 3. Added at weight 2^6.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  16  signed product, a×b mod 2^16.
- busy  out  1  high in any state except IDLE.

Clock is `clk`. Reset is `rst`: one clock domain, synchronous, active-high.

## Operation
- FSM states: IDLE, ACC, DONE.
- Registers: operand registers for pp01..pp03; 16-bit accumulator `acc`; 2-bit step counter `cnt`.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).
- `product` = `acc`. It is held stable throughout DONE.
- Accept (IDLE, in_valid=1):
  - capture pp01..pp03;
  - acc ← zext16(pp00) + (neg3 << 6);
  - cnt ← 1; state ← ACC.
- ACC, cnt=1: acc ← acc + zext16(pp01).
- ACC, cnt=2: acc ← acc + (zext16(pp02) << 2).
- ACC, cnt=3: acc ← acc + (zext16(pp03) << 4); state ← DONE.
- All additions are modulo 2^16. Carries out of bit 15 are discarded by design; the sign-extension constants in the rows depend on this wrap.
- DONE with out_ready=1: state ← IDLE. `acc` keeps its value but `out_valid` falls.
- DONE with out_ready=0: hold all state indefinitely.
- Inputs are ignored outside IDLE, whatever in_valid does.
- in_valid=0 in IDLE: no state change.
- No overlap: a new operand set is accepted only on the cycle after the DONE→IDLE transfer. Peak throughput is one product per 5 cycles.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0. So in_ready=1, out_valid=0, busy=0, product=0x0000.
- Reset has priority over every transition, including mid-ACC and DONE. Any result in flight is dropped and no out_valid pulse is produced.
- Latency, default build: accept on edge E0; out_valid is high after edge E3 (3 cycles).
- Output transfer occurs on the edge where out_valid=1 and out_ready=1. in_ready rises after that edge.
- in_ready and out_valid are registered-state decodes, with no combinational path from inputs.
- out_ready does not feed back to in_ready combinationally.

## Configuration
Macro: `PPACC_DUAL_ROW_EN`.
- Undefined (default): one row added per cycle, as described above. Latency is 3 cycles; initiation interval is 5 cycles.
- Defined: two rows added per cycle.
  - Accept: acc ← zext16(pp00) + zext16(pp01) + (neg3 << 6), with cnt ← 2.
  - ACC, cnt=2: acc ← acc + (zext16(pp02) << 2) + (zext16(pp03) << 4); state ← DONE.
  - Latency is 1 cycle after accept (out_valid after E1). Initiation interval is 3 cycles.
  - Handshake, reset and wrap rules are unchanged.

## Test plan
Rows are generated by a golden Booth and sign-extension model from operands a and b.
- a=−128, b=−128, out_ready=1 → product=0x4000; out_valid for exactly 1 cycle, 3 cycles after accept (1 with the macro).
- a=127, b=−1 → 0xFF81. a=0, b=0 → 0x0000. a=−1, b=−1 → 0x0001. This checks the neg3 correction and wrap.
- out_ready=0 for 6 cycles in DONE, a=5, b=−7 → product holds 0xFFDD, in_ready stays 0, new in_valid is ignored. Raising out_ready gives one transfer, then in_ready=1.
- Assert rst during ACC, cnt=2 → next cycle state=IDLE, product=0x0000, out_valid never asserts. A following operand set a=3, b=4 yields 0x000C.
- Back-to-back: in_valid held high with 256 random pairs → every product matches a×b. Accepts are spaced exactly 5 cycles apart (3 with the macro).
- Exhaustive sweep of all 65536 (a, b) pairs against the reference multiply, run in both macro builds.
